// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Sub-word loads are extracted and extended; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e      state_q, state_d;
    logic        accept;
    logic        req_err;

    logic        store_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wbuf_q;
    logic [31:0] rdata_q;
    logic        err_q;

    // Big-endian lanes: byte offset 0 is [31:24], half offset 0 is [31:16].
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        unique case (off)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   res = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00: begin
                unique case (off)
                    2'd0: res[31:24] = wdata[7:0];
                    2'd1: res[23:16] = wdata[7:0];
                    2'd2: res[15:8]  = wdata[7:0];
                    2'd3: res[7:0]   = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    res[15:0] = wdata[15:0];
                end else begin
                    res[31:16] = wdata[15:0];
                end
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    assign accept = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11) begin
            req_err = 1'b1;
        end
        if (req_size == 2'b01 && req_addr[0]) begin
            req_err = 1'b1;
        end
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) begin
            req_err = 1'b1;
        end
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
            req_err = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_store && req_size == 2'b10) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:   state_d = store_q ? StWr : StResp;
            StWr:   state_d = StResp;
            StResp: state_d = StIdle;
        endcase
    end

    // Output logic; memory strobes and address decode purely from state so reset clears them
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'b0;
        mem_wdata  = 32'b0;
        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StRd: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[31:2], 2'b00};
            end
            StWr: begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = wbuf_q;
            end
            StResp: resp_valid = 1'b1;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Request latch and datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            wbuf_q     <= 32'b0;
            rdata_q    <= 32'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                store_q    <= req_store;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                wbuf_q     <= req_wdata;
                rdata_q    <= 32'b0;
                err_q      <= req_err;
            end else if (state_q == StRd) begin
                if (store_q) begin
                    wbuf_q <= merge_lane(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                end else begin
                    rdata_q <= load_extend(mem_rdata, size_q, addr_q[1:0], unsigned_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases with literal expectations plus
// randomized requests checked against a byte-lane memory model.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    int checks = 0;
    int errors = 0;

    logic [31:0] dmem    [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Data memory: combinational read, write on rising edge, initialised by reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) dmem[i] <= (i == 0) ? 32'd99 : 32'(i);
        end else if (mem_write && mem_addr[31:2] < MEM_WORDS) begin
            dmem[mem_addr[6:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = dmem[mem_addr[6:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = (i == 0) ? 32'd99 : 32'(i);
    endtask

    task automatic scramble_req();
        req_store    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
    endtask

    // Per-cycle invariants
    always @(negedge clk) begin
        if (rst) begin
            check("rw_exclusive", 32'(mem_read && mem_write), 32'd0);
            check("addr_word_aligned", 32'(mem_addr[1:0]), 32'd0);
        end
    end

    // One request; called and returns at a falling edge
    task automatic xact(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd);
        logic [7:0]  b [4];
        logic [31:0] exp_rdata, new_word;
        logic        e;
        int          off, idx, exp_lat, exp_reads, exp_writes, n, reads, writes, w;
        bit          done;

        off = int'(a % 4);
        e = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
            (a / 4 >= MEM_WORDS);
        exp_rdata = 32'b0;
        new_word  = 32'b0;
        idx       = 0;
        if (!e) begin
            idx = int'(a / 4);
            for (int k = 0; k < 4; k++) b[k] = ref_mem[idx][31 - 8 * k -: 8];
            if (!st) begin
                case (sz)
                    2'd0: exp_rdata = un ? 32'(b[off]) : 32'($signed(b[off]));
                    2'd1: exp_rdata = un ? 32'({b[off], b[off + 1]})
                                         : 32'($signed({b[off], b[off + 1]}));
                    default: exp_rdata = {b[0], b[1], b[2], b[3]};
                endcase
            end else begin
                case (sz)
                    2'd0: b[off] = wd[7:0];
                    2'd1: begin
                        b[off]     = wd[15:8];
                        b[off + 1] = wd[7:0];
                    end
                    default: for (int k = 0; k < 4; k++) b[k] = wd[31 - 8 * k -: 8];
                endcase
                new_word = {b[0], b[1], b[2], b[3]};
                ref_mem[idx] = new_word;
            end
        end
        exp_lat    = e ? 1 : ((st && sz != 2'd2) ? 3 : 2);
        exp_reads  = (e || (st && sz == 2'd2)) ? 0 : 1;
        exp_writes = (!e && st) ? 1 : 0;

        w = 0;
        while (!req_ready) begin
            if (w >= 20) begin
                check("ready_timeout", 32'(req_ready), 32'd1);
                return;
            end
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble_req();

        n = 0; reads = 0; writes = 0; done = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
            if (mem_read) begin
                reads++;
                check("rd_addr", mem_addr, {a[31:2], 2'b00});
            end
            if (mem_write) begin
                writes++;
                check("wr_addr", mem_addr, {a[31:2], 2'b00});
                check("wr_data", mem_wdata, new_word);
            end
            if (resp_valid) done = 1;
        end
        if (!done) begin
            check("resp_timeout", 32'(resp_valid), 32'd1);
            return;
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", 32'(resp_err), 32'(e));
        check("mem_read_count", 32'(reads), 32'(exp_reads));
        check("mem_write_count", 32'(writes), 32'(exp_writes));
        @(negedge clk);
        check("resp_one_pulse", 32'(resp_valid), 32'd0);
        check("resp_rdata_held", resp_rdata, exp_rdata);
    endtask

    // Reset hits a sub-word store in RD (in_wr=0) or WR (in_wr=1)
    task automatic reset_mid(input bit in_wr);
        int rv, wr;
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h9; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_rd", 32'(mem_read), 32'd1);
        if (in_wr) begin
            @(negedge clk);
            check("rst_pre_wr", 32'(mem_write), 32'd1);
        end
        #1 rst = 1'b0;
        #1;
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        ref_reset();
        rv = 0; wr = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) rv++;
            if (mem_write) wr++;
        end
        rst = 1'b1;
        check("rst_ready_after", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) rv++;
            if (mem_write) wr++;
        end
        check("rst_no_resp", 32'(rv), 32'd0);
        check("rst_no_write", 32'(wr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        req_valid = 1'b0;
        scramble_req();
        ref_reset();
        repeat (3) @(negedge clk);
        check("reset_mem_read", 32'(mem_read), 32'd0);
        check("reset_mem_write", 32'(mem_write), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_resp_err", 32'(resp_err), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;
        check("reset_req_ready", 32'(req_ready), 32'd1);

        xact(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        check("lit_lw_14", resp_rdata, 32'h0000_0005);
        xact(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_00AB);
        check("lit_sb_word2", dmem[2], 32'h00AB_0002);
        xact(1'b0, 2'd0, 1'b0, 32'h09, 32'h0);
        check("lit_lb_09", resp_rdata, 32'hFFFF_FFAB);
        xact(1'b0, 2'd0, 1'b1, 32'h09, 32'h0);
        check("lit_lbu_09", resp_rdata, 32'h0000_00AB);
        xact(1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000_8001);
        check("lit_sh_word3", dmem[3], 32'h0000_8001);
        xact(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0);
        check("lit_lh_0e", resp_rdata, 32'hFFFF_8001);
        xact(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
        check("lit_lhu_0e", resp_rdata, 32'h0000_8001);
        xact(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
        check("lit_err_lw06", 32'(resp_err), 32'd1);
        xact(1'b1, 2'd1, 1'b0, 32'h03, 32'h1234);
        check("lit_err_sh03", 32'(resp_err), 32'd1);
        xact(1'b0, 2'd3, 1'b0, 32'h04, 32'h0);
        check("lit_err_size3", 32'(resp_err), 32'd1);
        xact(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        check("lit_err_lw80", 32'(resp_err), 32'd1);
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lit_lw_10", resp_rdata, 32'hDEAD_BEEF);

        reset_mid(1'b0);
        xact(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        check("lit_lw_after_rst_rd", resp_rdata, 32'h0000_0005);
        reset_mid(1'b1);
        xact(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
        check("lit_lw_after_rst_wr", resp_rdata, 32'h0000_0002);

        for (int t = 0; t < 250; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else a = 32'($urandom_range(0, MEM_WORDS + 2)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            xact(1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
